pwm_ramp_ctrl: RTL and testbench
================================

# pwm_ramp_ctrl

Duty-cycle sequencer that sits in front of the PWM generator and drives its 7-bit duty-cycle input. It accepts a target duty (0–100 %) and a ramp rate over a valid/ready handshake. It then slews its duty output toward the target by 1 % per programmed number of PWM periods, updating only on PWM period boundaries so the generator never sees a mid-period duty change. Used for soft-start and soft-stop of loads driven from the PWM output pins.

## Interface

Parameters:
- DC_MAX, 100, maximum legal duty value; larger requests are clamped to this.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low; clock clk.
- ena  input  1  block enable; low pauses ramping and blocks new requests.
- period_tick  input  1  one-cycle pulse at each PWM counter wrap (8-bit counter 255→0).
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid & req_ready at a rising edge.
- req_dc  input  7  target duty in percent.
- req_rate  input  4  PWM periods per 1 % step; 0 = jump straight to target.
- abort  input  1  stop the ramp and hold the current duty.
- dc_out  output  7  duty to the PWM generator, 0..DC_MAX.
- busy  output  1  high in RAMP and DONE.
- done  output  1  one-cycle pulse when the target is reached.
- sat  output  1  last accepted req_dc exceeded DC_MAX; held until the next accept.

## Operation

- States: IDLE, RAMP, DONE.
- Reset values: state IDLE, dc_out=0, tgt=0, rate=0, tick_cnt=0, busy=0, done=0, sat=0.
- req_ready = (state==IDLE) & ena & ~abort.
  - Derived combinationally from registered state and inputs only.
  - Does not depend on req_valid.
- Accept, IDLE→RAMP:
  - tgt <= min(req_dc, DC_MAX).
  - sat <= (req_dc > DC_MAX).
  - rate <= req_rate.
  - tick_cnt <= 0.
- RAMP, on a cycle with period_tick & ena & ~abort:
  - rate==0: dc_out <= tgt.
  - rate!=0 and tick_cnt==rate-1: dc_out moves 1 toward tgt (+1 if below, −1 if above) and tick_cnt <= 0.
  - Otherwise: tick_cnt <= tick_cnt+1.
- RAMP→DONE:
  - On the edge where dc_out is written equal to tgt.
  - Or on any edge in RAMP where dc_out already equals tgt; this covers a request equal to the current duty, which completes without waiting for a tick.
- DONE: done=1 for exactly one cycle, then IDLE.
- abort while in RAMP:
  - Next state IDLE; dc_out frozen at its current value; no done pulse.
  - tick_cnt cleared; sat unchanged.
- abort in IDLE or DONE: no effect, except that it deasserts req_ready.
- ena low:
  - period_tick ignored; tick_cnt and dc_out hold.
  - State is retained; a DONE state still completes to IDLE.
- Arithmetic:
  - dc_out never leaves 0..DC_MAX.
  - Step direction is computed from the unsigned comparison dc_out vs tgt.
  - tick_cnt is 4-bit and never exceeds rate-1.
- Reset mid-ramp: all registers return to reset values immediately (asynchronous); dc_out=0.

## Timing

- Accept edge to first possible dc_out change: the first period_tick edge strictly after accept.
- rate=N≥1: one 1 % step per N period_tick pulses.
  - Full ramp of |tgt−dc_out| = D takes D·N ticks.
- done asserts in the cycle after the edge that wrote dc_out==tgt.
  - busy falls in the cycle after done.
- dc_out is registered and changes only on an edge where period_tick=1, which is the PWM wrap. The PWM generator therefore samples a stable duty for each full period.
- Back-to-back requests: req_ready returns high in the cycle after done, i.e. a minimum of 2 cycles between accepts.
- abort and period_tick in the same cycle: abort wins; dc_out is not updated.

## Test plan

- Reset: assert reset low mid-operation -> dc_out=0, busy=0, done=0, sat=0, req_ready=1 (with ena=1) immediately and after release.
- Up ramp: from 0, req_dc=10, req_rate=2, tick every 256 cycles -> dc_out rises 1 every 2 ticks, reaches 10 after 20 ticks, single done pulse one cycle later.
- Jump and clamp:
  - req_dc=75, rate=0 -> dc_out=75 on the first tick.
  - Then req_dc=120, rate=0 -> sat=1, dc_out=100, never above 100.
- Down ramp plus abort: from 100, req_dc=0, rate=1; abort after 30 ticks -> dc_out holds 70, no done, req_ready=1 next cycle.
- Pause: ena=0 for 5 ticks mid-ramp -> dc_out and tick_cnt frozen, req_ready=0; ramp resumes exactly where it stopped after ena=1.
- Equal target: dc_out=40, request req_dc=40, rate=5 -> done within 2 cycles of accept, dc_out unchanged.

Source files
------------

// File: rtl/pwm_ramp_ctrl_if.sv
// Request channel for pwm_ramp_ctrl: target duty and ramp rate over valid/ready.
//   req_valid  request present (master -> slave)
//   req_ready  request accepted on a rising edge with req_valid (slave -> master)
//   req_dc     target duty in percent, 7 bits
//   req_rate   PWM periods per 1 % step, 4 bits; 0 = jump to target
interface pwm_ramp_ctrl_if;
    localparam int unsigned DC_W   = 7;
    localparam int unsigned RATE_W = 4;

    logic              req_valid;
    logic              req_ready;
    logic [DC_W-1:0]   req_dc;
    logic [RATE_W-1:0] req_rate;

    modport master (output req_valid, output req_dc, output req_rate, input req_ready);
    modport slave  (input req_valid, input req_dc, input req_rate, output req_ready);
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle sequencer in front of the PWM generator: slews dc_out toward a
// requested target by 1 % per programmed number of PWM periods, updating only
// on PWM wrap so the generator always sees a stable duty for a whole period.
//   clk          system clock, rising edge
//   reset        asynchronous, active-low
//   ena          block enable; low pauses ramping and blocks new requests
//   period_tick  one-cycle pulse at each PWM counter wrap
//   req          request channel (slave side)
//   abort        stop the ramp and hold the current duty
//   dc_out       duty to the PWM generator, 0..DC_MAX
//   busy         high in RAMP and DONE
//   done         one-cycle pulse when the target is reached
//   sat          last accepted request exceeded DC_MAX
module pwm_ramp_ctrl #(
    parameter int unsigned DC_MAX = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ena,
    input  logic                  period_tick,
    pwm_ramp_ctrl_if.slave        req,
    input  logic                  abort,
    output logic [6:0]            dc_out,
    output logic                  busy,
    output logic                  done,
    output logic                  sat
);
    localparam int unsigned DC_W   = 7;
    localparam int unsigned RATE_W = 4;
    localparam logic [DC_W-1:0] DC_LIMIT = DC_W'(DC_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [DC_W-1:0]     tgt;
    logic [RATE_W-1:0]   rate;
    logic [RATE_W-1:0]   tick_cnt;
    logic [DC_W-1:0]     dc_step_c;

    // Ready depends only on registered state and the gating inputs, never on valid.
    assign req.req_ready = (state == IDLE) && ena && !abort;

    // One percent toward the target; only used while dc_out != tgt.
    assign dc_step_c = (dc_out < tgt) ? dc_out + DC_W'(1) : dc_out - DC_W'(1);

    // Sequencer state, duty register and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            dc_out   <= '0;
            tgt      <= '0;
            rate     <= '0;
            tick_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sat      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req.req_valid && req.req_ready) begin
                        tgt      <= (req.req_dc > DC_LIMIT) ? DC_LIMIT : req.req_dc;
                        sat      <= (req.req_dc > DC_LIMIT);
                        rate     <= req.req_rate;
                        tick_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= RAMP;
                    end
                end
                RAMP: begin
                    if (abort) begin
                        // Abort beats a coincident tick: duty freezes where it is.
                        tick_cnt <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (dc_out == tgt) begin
                        // Target already reached (e.g. request equal to current duty).
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (period_tick && ena) begin
                        if (rate == '0) begin
                            dc_out <= tgt;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else if (tick_cnt == rate - RATE_W'(1)) begin
                            dc_out   <= dc_step_c;
                            tick_cnt <= '0;
                            if (dc_step_c == tgt) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + RATE_W'(1);
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: reset, up ramp, jump/clamp, abort,
// pause, equal target, back-to-back requests and asynchronous reset mid-ramp.
module tb_pwm_ramp_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic       period_tick;
    logic       abort;
    logic [6:0] dc_out;
    logic       busy;
    logic       done;
    logic       sat;

    int n_pass   = 0;
    int n_total  = 0;
    int done_cnt = 0;

    pwm_ramp_ctrl_if rif ();

    pwm_ramp_ctrl #(.DC_MAX(100)) dut (
        .clk         (clk),
        .reset       (reset),
        .ena         (ena),
        .period_tick (period_tick),
        .req         (rif),
        .abort       (abort),
        .dc_out      (dc_out),
        .busy        (busy),
        .done        (done),
        .sat         (sat)
    );

    always #5 clk = ~clk;

    // Count every done pulse, sampled mid-cycle.
    always @(negedge clk) if (done) done_cnt++;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pwm_tick();
        period_tick = 1'b1;
        cyc();
        period_tick = 1'b0;
    endtask

    task automatic send_req(input logic [6:0] d, input logic [3:0] r);
        rif.req_valid = 1'b1;
        rif.req_dc    = d;
        rif.req_rate  = r;
        cyc();
        rif.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_total++; if (dc_out !== 7'd0) $display("FAIL rst_dc: got %0d exp 0", dc_out); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b exp 0", done); else n_pass++;
        n_total++; if (sat !== 1'b0) $display("FAIL rst_sat: got %b exp 0", sat); else n_pass++;
        n_total++; if (rif.req_ready !== 1'b1) $display("FAIL rst_ready: got %b exp 1", rif.req_ready); else n_pass++;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        n_total++; if (dc_out !== 7'd0) $display("FAIL rst_rel_dc: got %0d exp 0", dc_out); else n_pass++;
        n_total++; if (rif.req_ready !== 1'b1) $display("FAIL rst_rel_ready: got %b exp 1", rif.req_ready); else n_pass++;
    endtask

    task automatic test_up_ramp();
        int d0;
        d0 = done_cnt;
        send_req(7'd10, 4'd2);
        n_total++; if (busy !== 1'b1) $display("FAIL up_busy: got %b exp 1", busy); else n_pass++;
        n_total++; if (dc_out !== 7'd0) $display("FAIL up_start: got %0d exp 0", dc_out); else n_pass++;
        for (int k = 1; k <= 20; k++) begin
            pwm_tick();
            n_total++;
            if (dc_out !== 7'(k / 2)) $display("FAIL up_tick%0d: got %0d exp %0d", k, dc_out, k / 2);
            else n_pass++;
            if (k < 20) repeat (255) cyc();
        end
        n_total++; if (done !== 1'b1) $display("FAIL up_done: got %b exp 1", done); else n_pass++;
        cyc();
        n_total++; if (done !== 1'b0) $display("FAIL up_done_once: got %b exp 0", done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL up_busy_fall: got %b exp 0", busy); else n_pass++;
        n_total++; if (rif.req_ready !== 1'b1) $display("FAIL up_ready: got %b exp 1", rif.req_ready); else n_pass++;
        n_total++; if (done_cnt - d0 !== 1) $display("FAIL up_done_cnt: got %0d exp 1", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_jump_clamp();
        send_req(7'd75, 4'd0);
        n_total++; if (dc_out !== 7'd10) $display("FAIL jump_pre: got %0d exp 10", dc_out); else n_pass++;
        pwm_tick();
        n_total++; if (dc_out !== 7'd75) $display("FAIL jump_dc: got %0d exp 75", dc_out); else n_pass++;
        n_total++; if (done !== 1'b1) $display("FAIL jump_done: got %b exp 1", done); else n_pass++;
        cyc();
        send_req(7'd120, 4'd0);
        n_total++; if (sat !== 1'b1) $display("FAIL clamp_sat: got %b exp 1", sat); else n_pass++;
        pwm_tick();
        n_total++; if (dc_out !== 7'd100) $display("FAIL clamp_dc: got %0d exp 100", dc_out); else n_pass++;
        cyc();
        repeat (3) begin pwm_tick(); cyc(); end
        n_total++; if (dc_out !== 7'd100) $display("FAIL clamp_hold: got %0d exp 100", dc_out); else n_pass++;
        n_total++; if (sat !== 1'b1) $display("FAIL clamp_sat_hold: got %b exp 1", sat); else n_pass++;
    endtask

    task automatic test_down_abort();
        int d0;
        send_req(7'd0, 4'd1);
        for (int k = 0; k < 30; k++) begin
            pwm_tick();
            repeat (3) cyc();
        end
        n_total++; if (dc_out !== 7'd70) $display("FAIL down_dc: got %0d exp 70", dc_out); else n_pass++;
        d0 = done_cnt;
        abort       = 1'b1;
        period_tick = 1'b1;
        cyc();
        period_tick = 1'b0;
        n_total++; if (dc_out !== 7'd70) $display("FAIL abort_dc: got %0d exp 70", dc_out); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b exp 0", busy); else n_pass++;
        n_total++; if (rif.req_ready !== 1'b0) $display("FAIL abort_ready_lo: got %b exp 0", rif.req_ready); else n_pass++;
        abort = 1'b0;
        #1;
        n_total++; if (rif.req_ready !== 1'b1) $display("FAIL abort_ready_hi: got %b exp 1", rif.req_ready); else n_pass++;
        pwm_tick();
        pwm_tick();
        n_total++; if (dc_out !== 7'd70) $display("FAIL abort_hold: got %0d exp 70", dc_out); else n_pass++;
        n_total++; if (done_cnt !== d0) $display("FAIL abort_no_done: got %0d exp %0d", done_cnt, d0); else n_pass++;
    endtask

    task automatic test_pause();
        send_req(7'd80, 4'd3);
        repeat (4) begin pwm_tick(); repeat (2) cyc(); end
        n_total++; if (dc_out !== 7'd71) $display("FAIL pause_pre: got %0d exp 71", dc_out); else n_pass++;
        ena = 1'b0;
        repeat (5) begin pwm_tick(); repeat (2) cyc(); end
        n_total++; if (dc_out !== 7'd71) $display("FAIL pause_hold: got %0d exp 71", dc_out); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL pause_busy: got %b exp 1", busy); else n_pass++;
        n_total++; if (rif.req_ready !== 1'b0) $display("FAIL pause_ready: got %b exp 0", rif.req_ready); else n_pass++;
        ena = 1'b1;
        pwm_tick();
        n_total++; if (dc_out !== 7'd71) $display("FAIL resume_t1: got %0d exp 71", dc_out); else n_pass++;
        pwm_tick();
        n_total++; if (dc_out !== 7'd72) $display("FAIL resume_t2: got %0d exp 72", dc_out); else n_pass++;
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        ena   = 1'b0;
        #1;
        n_total++; if (rif.req_ready !== 1'b0) $display("FAIL ena_ready_lo: got %b exp 0", rif.req_ready); else n_pass++;
        ena = 1'b1;
        #1;
        n_total++; if (rif.req_ready !== 1'b1) $display("FAIL ena_ready_hi: got %b exp 1", rif.req_ready); else n_pass++;
    endtask

    task automatic test_equal();
        int lat;
        send_req(7'd40, 4'd0);
        pwm_tick();
        n_total++; if (dc_out !== 7'd40) $display("FAIL eq_setup: got %0d exp 40", dc_out); else n_pass++;
        cyc();
        send_req(7'd40, 4'd5);
        lat = 1;
        while (done !== 1'b1 && lat < 2) begin
            cyc();
            lat++;
        end
        n_total++; if (done !== 1'b1) $display("FAIL eq_done: got %b exp 1 within 2 cycles", done); else n_pass++;
        n_total++; if (dc_out !== 7'd40) $display("FAIL eq_dc: got %0d exp 40", dc_out); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d0;
        n_total++; if (rif.req_ready !== 1'b0) $display("FAIL b2b_ready_done: got %b exp 0", rif.req_ready); else n_pass++;
        cyc();
        n_total++; if (rif.req_ready !== 1'b1) $display("FAIL b2b_ready_idle: got %b exp 1", rif.req_ready); else n_pass++;
        d0 = done_cnt;
        rif.req_valid = 1'b1;
        rif.req_dc    = 7'd40;
        rif.req_rate  = 4'd0;
        repeat (6) cyc();
        rif.req_valid = 1'b0;
        n_total++; if (done_cnt - d0 !== 2) $display("FAIL b2b_done_cnt: got %0d exp 2", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        send_req(7'd127, 4'd1);
        n_total++; if (sat !== 1'b1) $display("FAIL mid_sat: got %b exp 1", sat); else n_pass++;
        pwm_tick();
        pwm_tick();
        n_total++; if (dc_out !== 7'd42) $display("FAIL mid_dc: got %0d exp 42", dc_out); else n_pass++;
        #3;
        reset = 1'b0;
        #1;
        n_total++; if (dc_out !== 7'd0) $display("FAIL mid_rst_dc: got %0d exp 0", dc_out); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b exp 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL mid_rst_done: got %b exp 0", done); else n_pass++;
        n_total++; if (sat !== 1'b0) $display("FAIL mid_rst_sat: got %b exp 0", sat); else n_pass++;
        n_total++; if (rif.req_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b exp 1", rif.req_ready); else n_pass++;
        repeat (2) cyc();
        reset = 1'b1;
        pwm_tick();
        n_total++; if (dc_out !== 7'd0) $display("FAIL mid_rel_dc: got %0d exp 0", dc_out); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL mid_rel_busy: got %b exp 0", busy); else n_pass++;
        n_total++; if (rif.req_ready !== 1'b1) $display("FAIL mid_rel_ready: got %b exp 1", rif.req_ready); else n_pass++;
    endtask

    initial begin
        reset         = 1'b0;
        ena           = 1'b1;
        period_tick   = 1'b0;
        abort         = 1'b0;
        rif.req_valid = 1'b0;
        rif.req_dc    = 7'd0;
        rif.req_rate  = 4'd0;
        test_reset();
        test_up_ramp();
        test_jump_clamp();
        test_down_abort();
        test_pause();
        test_equal();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
